// File: rtl/bus_arbiter_rr.sv
// Bus arbiter: grants one of N_MASTERS, shifts in a serial slave address, holds the connection until release.
// Grant is registered on the request edge; the address takes SADDR_W more edges. Round-robin search when ARB_ROUND_ROBIN_EN is defined.
module bus_arbiter_rr #(
  parameter int N_MASTERS = 2,
  parameter int MIDX_W    = 1,
  parameter int N_SLAVES  = 3,
  parameter int SADDR_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] m_request,
  input  logic                 slave_select,
  output logic [N_MASTERS-1:0] m_grant,
  output logic [MIDX_W-1:0]    bus_grant,
  output logic                 busy,
  output logic [N_SLAVES-1:0]  slave_grant,
  output logic                 addr_err
);

  localparam int CNT_W = $clog2(SADDR_W + 1);

  typedef enum logic [1:0] {IDLE, ADDR, CONNECT} state_t;

  state_t               state, state_nxt;
  logic [SADDR_W-1:0]   addr_q, addr_nxt, addr_shift;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [N_MASTERS-1:0] m_grant_nxt;
  logic [MIDX_W-1:0]    bus_grant_nxt;
  logic                 busy_nxt;
  logic [N_SLAVES-1:0]  slave_grant_nxt;
  logic                 addr_err_nxt;
  logic [MIDX_W-1:0]    winner;
  logic                 owner_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [MIDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [MIDX_W-1:0] w_hi, w_lo;
  logic              found_hi;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    found_hi = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_request[i]) begin
        w_lo = MIDX_W'(i);
        if (i > int'(rr_ptr)) begin
          w_hi     = MIDX_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    winner = found_hi ? w_hi : w_lo;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_request[i]) winner = MIDX_W'(i);
    end
  end
`endif

  assign owner_req  = |(m_request & m_grant);
  assign addr_shift = SADDR_W'({addr_q, slave_select});

  always_comb begin
    state_nxt       = state;
    m_grant_nxt     = m_grant;
    bus_grant_nxt   = bus_grant;
    busy_nxt        = busy;
    slave_grant_nxt = slave_grant;
    addr_err_nxt    = 1'b0;
    addr_nxt        = addr_q;
    cnt_nxt         = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_nxt      = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (|m_request) begin
          for (int i = 0; i < N_MASTERS; i++) m_grant_nxt[i] = (int'(winner) == i);
          bus_grant_nxt = winner;
          busy_nxt      = 1'b1;
          cnt_nxt       = '0;
          addr_nxt      = '0;
          state_nxt     = ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_nxt    = winner;
`endif
        end
      end
      ADDR, CONNECT: begin
        if (!owner_req) begin
          // Release beats everything, including a completing address bit.
          m_grant_nxt     = '0;
          bus_grant_nxt   = '0;
          busy_nxt        = 1'b0;
          slave_grant_nxt = '0;
          cnt_nxt         = '0;
          addr_nxt        = '0;
          state_nxt       = IDLE;
        end else if (state == ADDR) begin
          addr_nxt = addr_shift;
          if (cnt_q == CNT_W'(SADDR_W - 1)) begin
            if (int'(addr_shift) < N_SLAVES) begin
              for (int s = 0; s < N_SLAVES; s++) slave_grant_nxt[s] = (int'(addr_shift) == s);
            end else begin
              addr_err_nxt = 1'b1;
            end
            state_nxt = CONNECT;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      m_grant     <= '0;
      bus_grant   <= '0;
      busy        <= 1'b0;
      slave_grant <= '0;
      addr_err    <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr      <= MIDX_W'(N_MASTERS - 1);
`endif
    end else begin
      state       <= state_nxt;
      m_grant     <= m_grant_nxt;
      bus_grant   <= bus_grant_nxt;
      busy        <= busy_nxt;
      slave_grant <= slave_grant_nxt;
      addr_err    <= addr_err_nxt;
      addr_q      <= addr_nxt;
      cnt_q       <= cnt_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr      <= rr_ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboarded random bench for bus_arbiter_rr, plus directed reset and 4-master pointer checks.
module tb_bus_arbiter_rr;
  localparam int N  = 2;
  localparam int MW = 1;
  localparam int NS = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  m_request;
  logic          slave_select;
  logic [N-1:0]  m_grant;
  logic [MW-1:0] bus_grant;
  logic          busy;
  logic [NS-1:0] slave_grant;
  logic          addr_err;

  logic [3:0] m_request4;
  logic       slave_select4;
  logic [3:0] m_grant4;
  logic [1:0] bus_grant4;
  logic       busy4;
  logic [2:0] slave_grant4;
  logic       addr_err4;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.N_MASTERS(N), .MIDX_W(MW), .N_SLAVES(NS), .SADDR_W(SW)) dut (
    .clk(clk), .reset(reset), .m_request(m_request), .slave_select(slave_select),
    .m_grant(m_grant), .bus_grant(bus_grant), .busy(busy),
    .slave_grant(slave_grant), .addr_err(addr_err));

  bus_arbiter_rr #(.N_MASTERS(4), .MIDX_W(2), .N_SLAVES(3), .SADDR_W(2)) dut4 (
    .clk(clk), .reset(reset), .m_request(m_request4), .slave_select(slave_select4),
    .m_grant(m_grant4), .bus_grant(bus_grant4), .busy(busy4),
    .slave_grant(slave_grant4), .addr_err(addr_err4));

  typedef struct {
    int w;
    int gcyc;
    int outcome;  // 0 aborted, 1 slave granted, 2 address error
    int sidx;
    int rcyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   ptr_m = N - 1;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbitration: scan from pointer+1 with wraparound, or lowest index.
  function automatic int pick(input logic [N-1:0] r);
    int rv;
    rv = int'(r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (ptr_m + i) % N;
      if (((rv >> j) & 1) != 0) return j;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (((rv >> i) & 1) != 0) return i;
    end
`endif
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge with the arbiter idle; returns 1 unit after the release edge.
  task automatic episode(input logic [N-1:0] r, input int addr, input int abort_k, input int hold);
    exp_t e;
    int   nb;
    m_request = r;
    e.w       = pick(r);
    ptr_m     = e.w;
    e.gcyc    = cyc + 1;
    e.sidx    = addr;
    if (abort_k >= 0) begin
      e.outcome = 0;
      e.rcyc    = e.gcyc + abort_k + 1;
      nb        = abort_k;
    end else begin
      e.outcome = (addr < NS) ? 1 : 2;
      e.rcyc    = e.gcyc + SW + hold + 1;
      nb        = SW;
    end
    exp_q.push_back(e);
    tick();
    for (int b = 0; b < nb; b++) begin
      slave_select = ((addr >> (SW - 1 - b)) & 1) != 0;
      tick();
    end
    if (abort_k < 0) begin
      for (int h = 0; h < hold; h++) begin
        slave_select = 1'($urandom_range(0, 1));
        m_request    = N'($urandom_range(0, (1 << N) - 1)) | (N'(1) << e.w);
        tick();
      end
    end
    m_request = m_request & ~(N'(1) << e.w);
    tick();
  endtask

  initial begin : monitor
    exp_t cur;
    int   seen;
    logic prev_busy, prev_err, active;
    prev_busy = 1'b0;
    prev_err  = 1'b0;
    active    = 1'b0;
    seen      = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy && !prev_busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant", 32'(busy), 32'(0));
            active = 1'b0;
          end else begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            seen   = 0;
            check("grant_cycle", 32'(cyc), 32'(cur.gcyc));
            check("bus_grant", 32'(bus_grant), 32'(cur.w));
            check("m_grant", 32'(m_grant), 32'(1 << cur.w));
          end
        end
        if (prev_err) check("addr_err_width", 32'(addr_err), 32'(0));
        if (active && busy && (addr_err || |slave_grant)) begin
          check("err_excl_slave", 32'(addr_err && |slave_grant), 32'(0));
          if (seen == 0) begin
            seen = addr_err ? 2 : 1;
            check("outcome_kind", 32'(seen), 32'(cur.outcome));
            check("outcome_cycle", 32'(cyc), 32'(cur.gcyc + SW));
            if (seen == 1) check("slave_grant", 32'(slave_grant), 32'(1 << cur.sidx));
          end
        end
        if (active && !busy && prev_busy) begin
          check("release_cycle", 32'(cyc), 32'(cur.rcyc));
          check("outcome_seen", 32'(seen), 32'(cur.outcome));
          check("idle_outputs", 32'({m_grant, bus_grant, slave_grant, addr_err}), 32'(0));
          active = 1'b0;
        end
        prev_busy = busy;
        prev_err  = addr_err;
      end
    end
  end

  initial begin : stim
    int a, k;
    reset         = 1'b0;
    m_request     = '0;
    slave_select  = 1'b0;
    m_request4    = '0;
    slave_select4 = 1'b0;
    @(negedge clk);
    check("rst_m_grant", 32'(m_grant), 32'(0));
    check("rst_bus_grant", 32'(bus_grant), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_slave_grant", 32'(slave_grant), 32'(0));
    check("rst_addr_err", 32'(addr_err), 32'(0));
    check("rst_busy4", 32'(busy4), 32'(0));
    tick();
    reset  = 1'b1;
    mon_en = 1'b1;

    // Both masters requesting continuously, then a mid-address abort by master 1.
    episode(N'(3), 2, -1, 1);
    episode(N'(3), 3, -1, 2);
    episode(N'(3), 1, -1, 0);
    episode(N'(3), 0, -1, 3);
    episode(N'(2), 2, 1, 0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom_range(0, (1 << SW) - 1);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, SW - 1) : -1;
      episode(N'($urandom_range(1, (1 << N) - 1)), a, k, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        m_request = '0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    m_request = '0;
    repeat (4) tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    mon_en = 1'b0;

    // Asynchronous reset while connected.
    m_request = N'(1);
    tick();
    slave_select = 1'b1;
    tick();
    slave_select = 1'b0;
    tick();
    tick();
    check("pre_reset_slave", 32'(slave_grant), 32'(4));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_m_grant", 32'(m_grant), 32'(0));
    check("mid_rst_bus_grant", 32'(bus_grant), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_slave", 32'(slave_grant), 32'(0));
    m_request = '0;
    tick();
    reset     = 1'b1;
    m_request = N'(1);
    tick();
    check("post_rst_m_grant", 32'(m_grant), 32'(1));
    check("post_rst_bus_grant", 32'(bus_grant), 32'(0));
    m_request = '0;
    tick();
    check("post_rst_release", 32'(busy), 32'(0));

    // Four masters: leave the pointer at 1, then request 1010.
    m_request4 = 4'b0010;
    tick();
    check("m4_first_grant", 32'(bus_grant4), 32'(1));
    repeat (3) tick();
    m_request4 = 4'b0000;
    tick();
    m_request4 = 4'b1010;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    check("m4_rr_m_grant", 32'(m_grant4), 32'(8));
    check("m4_rr_bus_grant", 32'(bus_grant4), 32'(3));
`else
    check("m4_fp_m_grant", 32'(m_grant4), 32'(2));
    check("m4_fp_bus_grant", 32'(bus_grant4), 32'(1));
`endif
    m_request4 = 4'b0000;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised bus arbiter for the system bus. It grants one of `N_MASTERS` requesting masters and then receives that master's serial slave address on `slave_select`. Once the address is complete it drives a one-hot slave grant and holds the connection until the master releases its request. It generalises the fixed two-master/three-slave arbiter with three additions: any master count, round-robin fairness, and address-error detection.

## Interface
- `N_MASTERS`, default 2: number of requesting masters (≥2).
- `MIDX_W`, default 1: width of the encoded master index. Must satisfy `MIDX_W ≥ clog2(N_MASTERS)`.
- `N_SLAVES`, default 3: number of slaves.
- `SADDR_W`, default 2: serial slave-address length. Must satisfy `2^SADDR_W ≥ N_SLAVES`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m_request`  in  N_MASTERS  per-master bus request, level-held for the whole transaction.
- `slave_select`  in  1  serial slave address from the granted master, MSB first.
- `m_grant`  out  N_MASTERS  one-hot grant to the winning master.
- `bus_grant`  out  MIDX_W  encoded index of the granted master; valid while `busy`.
- `busy`  out  1  bus owned (ADDR or CONNECT state).
- `slave_grant`  out  N_SLAVES  one-hot selected slave; all-zero until the address completes.
- `addr_err`  out  1  one-cycle pulse when the received address is ≥ `N_SLAVES`.

## Operation
- Reset (`reset`=0, takes effect immediately):
  - state = IDLE.
  - All outputs are 0.
  - Shift register and bit counter are 0.
  - RR pointer = `N_MASTERS-1`, so master 0 wins first.
- IDLE:
  - Stay here if `m_request`==0.
  - Otherwise choose winner `w`, register `m_grant[w]`=1, `bus_grant`=w, `busy`=1, bit counter = 0, then go to ADDR.
  - Winner selection uses the RR pointer (see Configuration). After each grant the pointer is set to `w`.
- ADDR:
  - Each cycle, shift `slave_select` into the address register and increment the bit counter.
  - When the counter reaches `SADDR_W-1` the final bit is shifted in, and on that same edge:
    - address < `N_SLAVES`: assert `slave_grant[addr]`.
    - otherwise: `slave_grant` stays 0 and `addr_err` pulses for 1 cycle.
  - Then go to CONNECT.
- CONNECT: hold all grants until `m_request[w]`==0.
- Release (ADDR or CONNECT):
  - A sampled `m_request[w]`==0 clears `m_grant`, `bus_grant`, `busy` and `slave_grant` on that edge and returns to IDLE.
  - In ADDR, the partial address is discarded and no `slave_grant`/`addr_err` is produced.
- Requests from non-granted masters are ignored while `busy`. There is no pre-emption.
- The counter is ceil(log2(SADDR_W+1)) bits wide and is never allowed to wrap.

## Timing
- Request sampled high at edge t in IDLE → `m_grant`/`bus_grant`/`busy` high after edge t (zero added cycles).
- Address bits are sampled at edges t+1 … t+SADDR_W. `slave_grant` (or `addr_err`) is valid after edge t+SADDR_W.
- Release sampled at edge r → all grants low after r.
- IDLE is entered for at least one cycle, so the earliest next grant is after edge r+1 (one turnaround cycle).
- Simultaneous release and new requests: the release wins that edge, and arbitration happens at r+1 against the then-current requests.
- Reset deassertion is synchronised by the user. The first grant is possible at the first edge after `reset` goes high.
- `addr_err` is exactly one cycle wide and never coincides with a nonzero `slave_grant`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Search starts at index pointer+1 and wraps modulo `N_MASTERS`.
  - The first requester found wins.
- Undefined:
  - Fixed priority: the lowest requesting index always wins.
  - The pointer register is not built.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset mid-CONNECT (N_MASTERS=2): drive `reset`=0 between edges → `m_grant`, `bus_grant`, `busy`, `slave_grant` read 0 before the next edge; after release, master 0 request → grant to master 0.
- Master 0 requests, `slave_select` bits 1,0 → `m_grant`=2'b01, `bus_grant`=0, `busy`=1 after edge t; `slave_grant`=3'b100 after t+2; drop request → all 0 after the following edge.
- Address bits 1,1 (=3, N_SLAVES=3) → `addr_err`=1 for exactly one cycle after t+2, `slave_grant`=0, `busy` held until release.
- Masters 0 and 1 request continuously, each releasing after CONNECT:
  - `ARB_ROUND_ROBIN_EN` → grant order 0,1,0,1.
  - Without it → 0,0,0.
  - Every grant is separated by one IDLE cycle.
- Master 1 drops its request after 1 address bit → grants clear on that edge, no `slave_grant`, no `addr_err`.
- N_MASTERS=4, MIDX_W=2, RR build, pointer=1, `m_request`=4'b1010 → `m_grant`=4'b1000, `bus_grant`=3.
